// File: rtl/pb_debouncer.sv
// Pushbutton synchroniser, saturating-counter debouncer and press/release strobe generator.
// Optional auto-repeat of the press strobe while held: define DEBOUNCE_AUTOREPEAT_EN.
module pb_debouncer #(
   parameter int CNT_W         = 16,
   parameter bit PB_ACTIVE_LOW = 1'b0,
   parameter int RPT_W         = 22
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             PB,
   output logic             PB_state,
   output logic             PB_down,
   output logic             PB_up,
   output logic [CNT_W-1:0] PB_cnt
);

   localparam logic LP_PIN_RELEASED = PB_ACTIVE_LOW;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_state;
   logic             r_down;
   logic             r_up;
   logic [CNT_W-1:0] r_cnt;

   logic             w_pb_sync;
   logic             w_pending;
   logic             w_accept;
   logic             w_press;
   logic             w_release;
   logic             w_rpt_strobe;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Counter clears whenever the synchronised level agrees with the accepted state,
   // so one agreeing sample restarts the whole filter interval.
   function automatic logic [CNT_W-1:0] f_cnt_next(input logic             pending,
                                                   input logic [CNT_W-1:0] cnt);
      if (!pending || (&cnt)) begin
         return '0;
      end
      return cnt + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= LP_PIN_RELEASED;
         r_sync2 <= LP_PIN_RELEASED;
      end else begin
         r_sync1 <= PB;
         r_sync2 <= r_sync1;
      end
   end

   assign w_pb_sync = PB_ACTIVE_LOW ? ~r_sync2 : r_sync2;
   assign w_pending = (w_pb_sync != r_state);
   assign w_accept  = w_pending & (&r_cnt);
   assign w_press   = w_accept & ~r_state;
   assign w_release = w_accept &  r_state;
   assign w_cnt_nxt = f_cnt_next(w_pending, r_cnt);

`ifdef DEBOUNCE_AUTOREPEAT_EN
   logic [RPT_W-1:0] r_rpt;

   // A release accepted on the wrap edge suppresses the repeat strobe.
   assign w_rpt_strobe = r_state & (&r_rpt) & ~w_accept;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rpt <= '0;
      end else if (!r_state) begin
         r_rpt <= '0;
      end else begin
         r_rpt <= r_rpt + RPT_W'(1);
      end
   end
`else
   assign w_rpt_strobe = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= 1'b0;
         r_cnt   <= '0;
         r_down  <= 1'b0;
         r_up    <= 1'b0;
      end else begin
         r_state <= r_state ^ w_accept;
         r_cnt   <= w_cnt_nxt;
         r_down  <= w_press | w_rpt_strobe;
         r_up    <= w_release;
      end
   end

   assign PB_state = r_state;
   assign PB_down  = r_down;
   assign PB_up    = r_up;
   assign PB_cnt   = r_cnt;

endmodule

// File: tb/tb_pb_debouncer.sv
// Scoreboard bench for pb_debouncer (CNT_W=4, RPT_W=6): an active-high and an active-low instance.
module tb_pb_debouncer;

   localparam int CNT_W = 4;
   localparam int RPT_W = 6;
   localparam int LAT   = (1 << CNT_W) + 1;

   typedef struct {
      int   cyc;
      logic dn;
      logic up;
      logic st;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             PB;
   logic             PB_state;
   logic             PB_down;
   logic             PB_up;
   logic [CNT_W-1:0] PB_cnt;

   logic             PB_al;
   logic             al_state;
   logic             al_down;
   logic             al_up;
   logic [CNT_W-1:0] al_cnt;

   int  cyc   = 0;
   int  total = 0;
   int  bad   = 0;
   ev_t q_hi[$];
   ev_t q_al[$];

   pb_debouncer #(.CNT_W(CNT_W), .PB_ACTIVE_LOW(1'b0), .RPT_W(RPT_W)) u_dut (
      .clk(clk), .rst_n(rst_n), .PB(PB),
      .PB_state(PB_state), .PB_down(PB_down), .PB_up(PB_up), .PB_cnt(PB_cnt));

   pb_debouncer #(.CNT_W(CNT_W), .PB_ACTIVE_LOW(1'b1), .RPT_W(RPT_W)) u_dut_al (
      .clk(clk), .rst_n(rst_n), .PB(PB_al),
      .PB_state(al_state), .PB_down(al_down), .PB_up(al_up), .PB_cnt(al_cnt));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic ev_t mk(input int c, input logic dn, input logic up, input logic st);
      ev_t e;
      e.cyc = c;
      e.dn  = dn;
      e.up  = up;
      e.st  = st;
      return e;
   endfunction

   // Monitors: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (PB_down || PB_up) begin
         if (q_hi.size() == 0) begin
            chk("hi_unexpected_strobe", {30'd0, PB_down, PB_up}, 32'd0);
         end else begin
            ev_t e;
            e = q_hi.pop_front();
            chk("hi_strobe_cycle", cyc, e.cyc);
            chk("hi_down", {31'd0, PB_down}, {31'd0, e.dn});
            chk("hi_up", {31'd0, PB_up}, {31'd0, e.up});
            chk("hi_state", {31'd0, PB_state}, {31'd0, e.st});
         end
      end
   end

   always @(negedge clk) begin
      if (al_down || al_up) begin
         if (q_al.size() == 0) begin
            chk("al_unexpected_strobe", {30'd0, al_down, al_up}, 32'd0);
         end else begin
            ev_t e;
            e = q_al.pop_front();
            chk("al_strobe_cycle", cyc, e.cyc);
            chk("al_down", {31'd0, al_down}, {31'd0, e.dn});
            chk("al_up", {31'd0, al_up}, {31'd0, e.up});
            chk("al_state", {31'd0, al_state}, {31'd0, e.st});
         end
      end
   end

   initial begin
      int c;
      int mx;
      rst_n = 1'b0;
      PB    = 1'b0;
      PB_al = 1'b1;
      step(3);
      chk("rst_state", {31'd0, PB_state}, 32'd0);
      chk("rst_down", {31'd0, PB_down}, 32'd0);
      chk("rst_up", {31'd0, PB_up}, 32'd0);
      chk("rst_cnt", {28'd0, PB_cnt}, 32'd0);
      chk("rst_al_cnt", {28'd0, al_cnt}, 32'd0);
      rst_n = 1'b1;
      step(4);
      chk("al_idle_state", {31'd0, al_state}, 32'd0);

      // Active-low pin: press is pin 1->0, release 0->1
      PB_al = 1'b0;
      c = cyc + 1;
      q_al.push_back(mk(c + LAT, 1'b1, 1'b0, 1'b1));
      step(20);
      PB_al = 1'b1;
      c = cyc + 1;
      q_al.push_back(mk(c + LAT, 1'b0, 1'b1, 1'b0));
      step(20);

      // Clean press
      PB = 1'b1;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b1, 1'b0, 1'b1));
      step(16);
      chk("press_state_before", {31'd0, PB_state}, 32'd0);
      chk("press_cnt_before", {28'd0, PB_cnt}, 32'd14);
      step(2);
      chk("press_state_after", {31'd0, PB_state}, 32'd1);
      chk("press_cnt_after", {28'd0, PB_cnt}, 32'd0);
      step(3);

      // Release
      PB = 1'b0;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b0, 1'b1, 1'b0));
      step(20);
      chk("release_state", {31'd0, PB_state}, 32'd0);

      // Bounce: 5-cycle toggles for 40 cycles, then hold pressed
      mx = 0;
      for (int i = 0; i < 8; i++) begin
         PB = (i % 2 == 0) ? 1'b1 : 1'b0;
         for (int k = 0; k < 5; k++) begin
            step(1);
            if (int'(PB_cnt) > mx) mx = int'(PB_cnt);
         end
      end
      chk("bounce_max_cnt", mx, 32'd5);
      chk("bounce_state", {31'd0, PB_state}, 32'd0);
      PB = 1'b1;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b1, 1'b0, 1'b1));
      step(20);
      PB = 1'b0;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b0, 1'b1, 1'b0));
      step(20);

      // Asynchronous reset while counting, button held through it
      PB = 1'b1;
      step(11);
      chk("mid_cnt", {28'd0, PB_cnt}, 32'd9);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", {28'd0, PB_cnt}, 32'd0);
      chk("async_rst_state", {31'd0, PB_state}, 32'd0);
      step(3);
      rst_n = 1'b1;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b1, 1'b0, 1'b1));
      step(20);
      chk("reaccept_state", {31'd0, PB_state}, 32'd1);
      PB = 1'b0;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b0, 1'b1, 1'b0));
      step(20);

      // Long hold: auto-repeat strobes only when the feature is built in
      PB = 1'b1;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b1, 1'b0, 1'b1));
`ifdef DEBOUNCE_AUTOREPEAT_EN
      for (int r = 1; r <= 4; r++) begin
         q_hi.push_back(mk(c + LAT + r * (1 << RPT_W), 1'b1, 1'b0, 1'b1));
      end
`endif
      step(LAT + 300);
      PB = 1'b0;
      c = cyc + 1;
      q_hi.push_back(mk(c + LAT, 1'b0, 1'b1, 1'b0));
      step(25);

      chk("hi_outstanding", q_hi.size(), 32'd0);
      chk("al_outstanding", q_al.size(), 32'd0);
      chk("final_state", {31'd0, PB_state}, 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
